// File: rtl/edl_button_pkg.sv
// edl_button_pkg: register map and counter sizing shared by the button controller files.
package edl_button_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE = 2'd2;
    localparam logic [1:0] ADDR_LONG = 2'd3;

    // Bits needed to hold values 0..n-1.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/edl_button_debounce.sv
// edl_button_debounce: one button channel (synchronizer, debounce, press pulse).
// EDL_BUTTON_LONG_PRESS_EN adds a saturating hold counter driving long_hit.
module edl_button_debounce
    import edl_button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 50000,
    parameter int LONG_PRESS_CYCLES = 50000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic stable,
    output logic press,
    output logic long_hit
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          settle;

    assign settle = (sync[1] != stable) && (cnt == CNT_MAX);
    assign press  = settle && sync[1];

    // Any return to the stable level wipes the count: no partial credit for bounces.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync   <= '0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            sync   <= {sync[0], din};
            cnt    <= (sync[1] == stable || settle) ? '0 : cnt + 1'b1;
            stable <= settle ? sync[1] : stable;
        end
    end

`ifdef EDL_BUTTON_LONG_PRESS_EN
    localparam int HW = cnt_width(LONG_PRESS_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYCLES);

    logic [HW-1:0] hold;

    // Fires only on the step into saturation, so once per press.
    assign long_hit = stable && (hold == HOLD_MAX - 1'b1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            hold <= '0;
        else
            hold <= !stable ? '0 : (hold == HOLD_MAX) ? hold : hold + 1'b1;
    end
`else
    assign long_hit = 1'b0;
`endif

endmodule

// File: rtl/edl_button_controller.sv
// edl_button_controller: Avalon-MM push-button supervisor with W1C press capture and maskable irq.
// EDL_BUTTON_LONG_PRESS_EN enables the LONG register (address 3); otherwise it reads 0.
module edl_button_controller
    import edl_button_pkg::*;
#(
    parameter int WIDTH             = 4,
    parameter int DEBOUNCE_CYCLES   = 50000,
    parameter int LONG_PRESS_CYCLES = 50000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] stable, press, long_hit, mask_q, edge_q, long_q, wr_bits;
    logic             wr;
    logic [31:0]      rd_mux;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        edl_button_debounce #(
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (in_port[i]),
            .stable  (stable[i]),
            .press   (press[i]),
            .long_hit(long_hit[i])
        );
    end

    assign wr      = chipselect && !write_n;
    assign wr_bits = writedata[WIDTH-1:0];

    // Set terms are OR-ed in after the clear so a same-cycle press wins over W1C.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q   <= '0;
            edge_q   <= '0;
            readdata <= '0;
        end else begin
            mask_q   <= (wr && address == ADDR_MASK) ? wr_bits : mask_q;
            edge_q   <= (edge_q & ~((wr && address == ADDR_EDGE) ? wr_bits : '0)) | press;
            readdata <= rd_mux;
        end
    end

`ifdef EDL_BUTTON_LONG_PRESS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            long_q <= '0;
        else
            long_q <= (long_q & ~((wr && address == ADDR_LONG) ? wr_bits : '0)) | long_hit;
    end
`else
    assign long_q = '0;
`endif

    always_comb
        rd_mux = (address == ADDR_DATA) ? 32'(stable) :
                 (address == ADDR_MASK) ? 32'(mask_q) :
                 (address == ADDR_EDGE) ? 32'(edge_q) : 32'(long_q);

    assign irq = |((edge_q | long_q) & mask_q);

endmodule

// File: tb/tb_edl_button_controller.sv
// tb_edl_button_controller: directed and random stimulus against a sample-window reference model.
// Honors EDL_BUTTON_LONG_PRESS_EN the same way as the design.
module tb_edl_button_controller;

    localparam int D = 8;
    localparam int L = 64;
`ifdef EDL_BUTTON_LONG_PRESS_EN
    localparam logic [31:0] LONG_EXP = 32'h1;
`else
    localparam logic [31:0] LONG_EXP = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    edl_button_controller #(
        .WIDTH(4), .DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model: hist[k] is the input sampled k edges ago (hist[0] = this edge).
    logic [3:0]  hist [0:D+1];
    logic [3:0]  m_stable, m_mask, m_edge, m_long;
    logic [31:0] m_rd;
    logic        m_irq;
    int          n_cyc;
    int          rise_t [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k <= D + 1; k++) hist[k] = '0;
        m_stable = '0; m_mask = '0; m_edge = '0; m_long = '0;
        m_rd = '0; m_irq = 1'b0; n_cyc = 0;
        for (int c = 0; c < 4; c++) rise_t[c] = 0;
    endtask

    // A channel adopts a new level once D consecutive samples (delayed two edges
    // through the synchronizer) all disagree with the current stable level.
    task automatic model_step();
        logic [3:0] press, lhit, nst, clr;
        logic       same, wr;
        n_cyc++;
        m_rd = (address == 2'd0) ? {28'd0, m_stable} :
               (address == 2'd1) ? {28'd0, m_mask} :
               (address == 2'd2) ? {28'd0, m_edge} : {28'd0, m_long};
        for (int k = D + 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = in_port;
        press = '0; lhit = '0; nst = m_stable;
        for (int c = 0; c < 4; c++) begin
            same = 1'b1;
            for (int k = 3; k <= D + 1; k++) if (hist[k][c] != hist[2][c]) same = 1'b0;
            if (same && hist[2][c] != m_stable[c]) begin
                nst[c] = hist[2][c];
                press[c] = hist[2][c];
                if (hist[2][c]) rise_t[c] = n_cyc;
            end
            if (m_stable[c] && n_cyc - rise_t[c] == L) lhit[c] = 1'b1;
        end
        wr = chipselect && !write_n;
        if (wr && address == 2'd1) m_mask = writedata[3:0];
        clr = (wr && address == 2'd2) ? writedata[3:0] : 4'd0;
        m_edge = (m_edge & ~clr) | press;
`ifdef EDL_BUTTON_LONG_PRESS_EN
        clr = (wr && address == 2'd3) ? writedata[3:0] : 4'd0;
        m_long = (m_long & ~clr) | lhit;
`endif
        m_stable = nst;
        m_irq = |((m_edge | m_long) & m_mask);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset_n) model_reset(); else model_step();
        #1;
        check("model_rd", readdata, m_rd);
        check("model_irq", {31'd0, irq}, {31'd0, m_irq});
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string tag);
        address = a;
        tick();
        check(tag, readdata, exp);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_rd", readdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = '0;
        model_reset();
        repeat (3) tick();
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) bus_read(2'(a), 32'd0, "reset_read");
        check("reset_irq", {31'd0, irq}, 32'd0);

        // Clean press on ch1: DATA shows it on the 11th edge counting the sampling edge.
        address = 2'd0; in_port = 4'b0010;
        repeat (10) tick();
        check("data_early", readdata, 32'h0);
        tick();
        check("data_latency", readdata, 32'h2);
        bus_read(2'd2, 32'h2, "edge_ch1");
        check("irq_unmasked", {31'd0, irq}, 32'd0);
        bus_write(2'd2, 32'h2);

        // Bouncing ch0 must not register until the level holds.
        address = 2'd0;
        for (int t = 0; t < 4; t++) begin
            in_port[0] = ~in_port[0];
            repeat (5) begin
                tick();
                check("bounce_data", readdata, 32'h2);
            end
        end
        in_port[0] = 1'b1;
        repeat (10) tick();
        check("bounce_early", readdata, 32'h2);
        tick();
        check("bounce_settled", readdata, 32'h3);
        bus_read(2'd2, 32'h1, "edge_ch0");
        bus_write(2'd2, 32'h1);
        bus_read(2'd2, 32'h0, "edge_ch0_clr");

        // Masked interrupt on ch2 and its W1C clear.
        bus_write(2'd1, 32'h4);
        address = 2'd2; in_port[2] = 1'b1;
        repeat (9) tick();
        check("irq_pre", {31'd0, irq}, 32'd0);
        tick();
        check("irq_set", {31'd0, irq}, 32'd1);
        bus_write(2'd2, 32'h4);
        check("irq_w1c", {31'd0, irq}, 32'd0);
        bus_write(2'd2, 32'h1);
        bus_read(2'd2, 32'h0, "edge_other_bit");

        // W1C landing on the same edge that ch3 stable rises: set wins.
        in_port[3] = 1'b1;
        repeat (9) tick();
        bus_write(2'd2, 32'h8);
        bus_read(2'd2, 32'h8, "edge_set_wins");

        // Long press on ch0.
        in_port = 4'b0000;
        repeat (12) tick();
        bus_write(2'd3, 32'hF);
        bus_write(2'd2, 32'hF);
        bus_read(2'd3, 32'h0, "long_cleared");
        address = 2'd3; in_port = 4'b0001;
        repeat (80) tick();
        check("long_set", readdata, LONG_EXP);
        bus_write(2'd3, 32'h1);
        address = 2'd3;
        repeat (20) tick();
        bus_read(2'd3, 32'h0, "long_no_reset");
        in_port = 4'b0000;
        repeat (12) tick();
        in_port = 4'b0001;
        repeat (20) tick();
        bus_read(2'd3, 32'h0, "long_short");
        in_port = 4'b0000;

        // Reset mid-debounce, with ch1 held through it.
        bus_write(2'd1, 32'hF);
        check("irq_before_rst", {31'd0, irq}, 32'd1);
        in_port = 4'b0010;
        repeat (4) tick();
        apply_reset();
        address = 2'd0;
        repeat (10) tick();
        check("held_rst_early", readdata, 32'h0);
        tick();
        check("held_rst_data", readdata, 32'h2);
        bus_read(2'd2, 32'h2, "held_rst_edge");

        // Random traffic against the model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < 4; c++) if ($urandom_range(0, 11) == 0) in_port[c] = ~in_port[c];
            address    = 2'($urandom_range(0, 3));
            chipselect = ($urandom_range(0, 3) == 0);
            write_n    = 1'($urandom_range(0, 1));
            writedata  = $urandom;
            if ($urandom_range(0, 599) == 0) apply_reset(); else tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/edl_button_controller.md
# edl_button_controller

Avalon-MM slave that conditions and supervises the board push-buttons feeding the EDL_Final Qsys system. Each button is synchronized, debounced and edge-detected. Captured press events are held in software-clearable registers and raise a maskable interrupt to the Nios II. It replaces polling of the raw PIO input with event-driven handling.

## Interface
- `WIDTH`, default 4: number of button channels (1..32).
- `DEBOUNCE_CYCLES`, default 50000: cycles a synchronized level must hold before it is accepted (>=2).
- `LONG_PRESS_CYCLES`, default 50000000: hold time for the long-press flag (used only with the macro; >=DEBOUNCE_CYCLES).
- `clk` in, 1 bit: system clock. One clock; all state on the rising edge.
- `reset_n` in, 1 bit: asynchronous, active-low reset.
- `address` in, 2 bits: word register select.
- `chipselect` in, 1 bit: slave select.
- `write_n` in, 1 bit: active-low write strobe, qualified by `chipselect`.
- `writedata` in, 32 bits: write data.
- `in_port` in, `WIDTH` bits: raw, asynchronous button levels, 1 = pressed.
- `readdata` out, 32 bits: registered read data.
- `irq` out, 1 bit: level interrupt, active high.

## Operation
- Per channel: 2-FF synchronizer, then debounce counter.
  - Counter clears whenever the synchronized value equals the stable value.
  - When they differ, the counter increments.
  - At count `DEBOUNCE_CYCLES-1` with the difference still present, stable takes the synchronized value and the counter clears.
  - A bounce (difference disappears) clears the counter. There is no partial credit.
- `press` pulse (1 cycle) = stable 0→1 transition.
- Register map (unused bits read 0):
  - 0 DATA (RO): stable levels.
  - 1 MASK (RW): irq enable per channel.
  - 2 EDGE (W1C): bit set by `press` and held until software writes 1 to that bit.
  - 3 LONG (W1C): long-press capture. Reads 0 without the macro.
- Writes occur when `chipselect` and `!write_n` are both high. Writes to DATA are ignored.
- `irq` = OR over channels of ((EDGE | LONG) & MASK).
- Simultaneous W1C and set on the same bit in the same cycle: set wins, so the bit stays 1.
- Reset values: all synchronizer, stable, counter, MASK, EDGE and LONG bits = 0; `readdata` = 0; `irq` = 0.
- An input held pressed through reset produces one `press` after synchronization plus debounce.

## Timing
- `readdata` is registered every cycle from the mux selected by `address`. Data is valid on the cycle after `address` is presented: read latency 1, no wait states.
- A clean input transition appears in DATA exactly `DEBOUNCE_CYCLES+2` cycles after the first `clk` edge that samples the new level.
- EDGE sets on the same edge that stable changes. `irq` asserts on that edge when the channel is masked on; it is a registered-output function with no added delay.
- W1C takes effect on the write edge. `irq` deasserts on that same edge if no other source remains set.
- MASK writes affect `irq` on the write edge.
- Asserting `reset_n` low mid-debounce or mid-hold immediately clears all state. No event is generated on release.

## Configuration
- `EDL_BUTTON_LONG_PRESS_EN` defined: each channel gets a saturating hold counter, `$clog2(LONG_PRESS_CYCLES+1)` bits wide.
  - The counter increments while stable = 1 and clears when stable = 0.
  - On reaching `LONG_PRESS_CYCLES` it sets the LONG bit once per press.
  - LONG contributes to `irq` under the same MASK.
- Undefined: no hold counters exist, register 3 reads 0, writes to it are ignored, and `irq` uses EDGE only.

## Structure
- Package `edl_button_pkg` holds:
  - register address constants `ADDR_DATA=0`, `ADDR_MASK=1`, `ADDR_EDGE=2`, `ADDR_LONG=3`;
  - a counter-width function.
- Sub-module `edl_button_debounce` is one channel: synchronizer, debounce counter, stable register, `press` pulse, and the optional hold counter. It is instantiated `WIDTH` times in a generate loop.
- The top level owns the registers, the read mux and `irq`.

## Test plan
Bench parameters: `WIDTH`=4, `DEBOUNCE_CYCLES`=8, `LONG_PRESS_CYCLES`=64.
- Reset with `in_port`=0000, then read all addresses → every read returns 0x0 and `irq`=0.
- Raise `in_port[1]` and hold → DATA=0x2 exactly 10 cycles later; EDGE=0x2; `irq` stays 0 with MASK=0.
- Toggle `in_port[0]` with pulses every 5 cycles, then hold high → no DATA change during toggling; DATA bit 0 is set 10 cycles after the final edge; EDGE=0x1, set once.
- Write MASK=0x4, then press ch2 → `irq`=1 on the cycle stable changes. Write EDGE=0x4 → `irq`=0 on the write edge. Write EDGE=0x1 (other bit) → EDGE unchanged.
- Issue a W1C of EDGE bit 3 on the exact cycle ch3 stable rises → EDGE bit 3 reads 1.
- With the macro, hold ch0 for 80 cycles → LONG=0x1 set once, and clearing it while still held does not re-set it. Release and press again for 20 cycles → LONG stays 0. Without the macro → address 3 reads 0.
